// File: rtl/lmc_sum_if.sv
// rtl/lmc_sum_if.sv - read port between lmc_sum and the LMC word RAM
interface lmc_sum_if #(
   parameter int ADDR_WIDTH = 2,
   parameter int DATA_WIDTH = 4
);
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [DATA_WIDTH-1:0] rd_data;

   modport master (output rd_addr, input rd_data);
   modport slave  (input rd_addr, output rd_data);
endinterface

// File: rtl/lmc_sum.sv
// rtl/lmc_sum.sv - walks the LMC word RAM, summing words and tracking the maximum
module lmc_sum #(
   parameter int ADDR_WIDTH = 2,
   parameter int DATA_WIDTH = 4,
   parameter int ACC_WIDTH  = 8
) (
   input  logic                  timer555,
   input  logic                  reset_n,
   input  logic                  start,
   lmc_sum_if.master             ram,
   output logic [ACC_WIDTH-1:0]  acc,
   output logic [DATA_WIDTH-1:0] max_val,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

   state_t                  state_q;
   logic                    s1_q, s2_q, s3_q;
   logic [ADDR_WIDTH-1:0]   index_q;
   logic [ACC_WIDTH-1:0]    acc_q;
   logic [DATA_WIDTH-1:0]   max_q;
   logic                    ovf_q;
   logic                    go;
   logic [ACC_WIDTH:0]      sum_d;

   assign go    = s2_q & ~s3_q;
   // One extra bit on the adder captures the carry-out for the sticky overflow.
   assign sum_d = {1'b0, acc_q} + {{(ACC_WIDTH + 1 - DATA_WIDTH){1'b0}}, ram.rd_data};

   always_ff @(posedge timer555 or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         s3_q    <= 1'b0;
         index_q <= '0;
         acc_q   <= '0;
         max_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         s1_q <= start;
         s2_q <= s1_q;
         s3_q <= s2_q;
         case (state_q)
            IDLE: begin
               if (go) begin
                  acc_q   <= '0;
                  max_q   <= '0;
                  ovf_q   <= 1'b0;
                  index_q <= '0;
                  state_q <= RUN;
               end
            end
            RUN: begin
               acc_q   <= sum_d[ACC_WIDTH-1:0];
               ovf_q   <= ovf_q | sum_d[ACC_WIDTH];
               if (ram.rd_data > max_q) begin
                  max_q <= ram.rd_data;
               end
               index_q <= index_q + 1'b1;
               if (index_q == LAST_ADDR) begin
                  state_q <= DONE;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy        = (state_q == RUN);
   assign done        = (state_q == DONE);
   assign ram.rd_addr = busy ? index_q : '0;
   assign acc         = acc_q;
   assign max_val     = max_q;
   assign overflow    = ovf_q;
endmodule

// File: doc/lmc_sum.md
# lmc_sum

Downstream consumer of the LMC word RAM. On a start request, it walks every RAM address through its own read-address port and sums the words into an accumulator. It also tracks the largest word and flags arithmetic overflow. Results are presented to the front panel, and a done pulse marks the end of each pass. It relies on the RAM's combinational read, where data is valid in the same cycle as the address.

## Interface
- ADDR_WIDTH, 2, RAM address width; a pass covers 2**ADDR_WIDTH words
- DATA_WIDTH, 4, RAM word width
- ACC_WIDTH, 8, accumulator width; must be ≥ DATA_WIDTH
- timer555  in  1  clock; all state changes on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  run request from the panel button; asynchronous to timer555, level input
- rd_addr  out  ADDR_WIDTH  RAM read address
- rd_data  in  DATA_WIDTH  RAM read data; combinational from rd_addr
- acc  out  ACC_WIDTH  running and final sum
- max_val  out  DATA_WIDTH  largest word seen in the current or last pass
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse in DONE
- overflow  out  1  sticky carry-out of acc for the current or last pass

## Operation
- **Start synchronizer:** start passes through two flops (s1, s2). A third flop s3 holds the previous s2. The trigger is `go = s2 & ~s3`.
- **State machine:** three states, IDLE, RUN and DONE. The reset state is IDLE.
- **IDLE:**
  - rd_addr = 0.
  - If go = 1: clear acc, max_val, overflow and the index counter, then go to RUN.
  - Otherwise acc, max_val and overflow hold their values.
- **RUN, one word per cycle:**
  - rd_addr = index.
  - acc <= acc + zero-extended rd_data, wrapping mod 2**ACC_WIDTH.
  - overflow <= overflow | carry-out of that add.
  - max_val <= rd_data if rd_data > max_val (unsigned compare).
  - index <= index + 1.
  - When index == 2**ADDR_WIDTH-1, the last add still occurs, then go to DONE. Index wraps to 0.
- **DONE:** done = 1 for this cycle only, then go to IDLE unconditionally.
- **Start edges:** a go pulse in RUN or DONE is discarded and never queued. Holding start high produces exactly one pass; a new pass needs start low then high again.
- **Outputs are registered:** busy = (state == RUN) and done = (state == DONE), both taken from state flops.
- **Reset:**
  - On reset_n low: state IDLE, and index, acc, max_val, overflow, s1, s2, s3 all go to 0.
  - Outputs at reset: rd_addr 0, acc 0, max_val 0, busy 0, done 0, overflow 0.
  - Reset mid-pass aborts the pass with no done pulse.
  - Because s3 resets to 0, start held high across reset release triggers one pass.

## Timing
- Edges are numbered with start rising between edge 0 and edge 1, held stable.
- **Synchronizer:** s1 = 1 after edge 1 and s2 = 1 after edge 2, so go is high in cycle 2–3. RUN is entered at edge 3.
- **Start latency:** 3 edges from start rising to busy = 1.
- **RUN:**
  - Lasts exactly 2**ADDR_WIDTH cycles: rd_addr 0, 1, 2, 3 in cycles 3–4, 4–5, 5–6, 6–7.
  - Adds are taken at edges 4, 5, 6 and 7.
- **DONE:** entered at edge 7, with done = 1 and busy = 0 in cycle 7–8.
- **Result timing:** acc, max_val and overflow are final from edge 7, coincident with done.
- **Return to IDLE:** at edge 8. The earliest next RUN is at edge 11, after a fresh start edge.
- **rd_data stability:** rd_data must be stable before each edge in RUN. The RAM must not be written during busy; if it is, the result is the value sampled per cycle.

## Test plan
1. RAM = {3,5,7,9}, start pulse → busy cycles 3–7, rd_addr 0,1,2,3, done at cycle 7 only, acc = 24, max_val = 9, overflow = 0.
2. ACC_WIDTH = 4, RAM = {15,15,1,0} → acc = 15 (31 mod 16), overflow = 1, max_val = 15. A second pass with RAM = {1,1,1,1} clears overflow, giving acc = 4.
3. Start held high for 20 cycles → exactly one done pulse. Releasing start then re-pressing it → a second pass with identical results.
4. Extra start edge during RUN (low at cycle 4, high at cycle 5) → ignored, only one done, acc unchanged from scenario 1.
5. reset_n low at cycle 5 of a pass → all outputs 0 immediately (asynchronous), no done. Start low at release → remains IDLE. Start high at release → new pass begins, with busy at the 3rd edge after release.
6. RAM all 0 → acc = 0, max_val = 0, overflow = 0, done still pulses at cycle 7.
